mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter between the instruction cache, the data cache and the single word-granular external memory port. Each cache's memory-side interface is presented unchanged on one arbiter port. The arbiter grants one transaction at a time, tracks the single outstanding read and routes its response back to the owner. It sits directly downstream of both `cache` instances and directly upstream of main memory.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `i_clk` in 1: global clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_I_ren`, `i_I_wen` in 1: I-port read and write strobes.
- `i_I_addr`, `i_I_wdata` in 32: I-port word address and write data.
- `o_I_ready` out 1: I-port request accepted this cycle.
- `o_I_valid` out 1: I-port read data valid.
- `o_I_rdata` out 32: I-port read data.
- `i_D_ren`, `i_D_wen`, `i_D_addr`, `i_D_wdata`, `o_D_ready`, `o_D_valid`, `o_D_rdata`: same as the I-port signals, for the D-port.
- `i_mem_ready` in 1: memory can accept a request this cycle.
- `o_mem_addr`, `o_mem_wdata` out 32: address and write data to memory.
- `o_mem_ren`, `o_mem_wen` out 1: read and write strobes to memory.
- `i_mem_rdata` in 32: read data from memory.
- `i_mem_valid` in 1: read data valid, one cycle per read.

## Operation
- Registered state:
  - `state` ∈ {IDLE, RD_WAIT}.
  - `owner`: port of the outstanding read, 0=I, 1=D.
  - `last`: last granted port, used only when round-robin is enabled.
- Port request: `req_X = i_X_ren | i_X_wen`.
  - If both strobes are high, the access is a read and wen is ignored.
- Grant, combinational, only in IDLE:
  - One requester: it wins.
  - Both requesting: D wins (see Configuration).
  - In RD_WAIT nothing is granted.
- Forwarding while a grant exists:
  - o_mem_addr and o_mem_wdata are the winner's values.
  - o_mem_ren is the winner's ren.
  - o_mem_wen is the winner's wen & ~ren.
  - With no grant: all memory outputs are 0.
- `o_X_ready = grant_X & i_mem_ready`.
  - A requester holds all its request lines until it sees ready.
  - The loser sees ready=0 and keeps its request held.
- Transitions:
  - IDLE→RD_WAIT on an accepted read (grant & ren & i_mem_ready); `owner` is set to the winner.
  - An accepted write stays in IDLE; the memory port may accept back-to-back writes.
  - RD_WAIT→IDLE on the cycle after i_mem_valid.
- Response routing:
  - `o_X_valid = i_mem_valid & (state==RD_WAIT) & (owner==X)`.
  - `o_I_rdata = o_D_rdata = i_mem_rdata`, broadcast; only the valid strobes are routed.
- i_mem_valid in IDLE is a protocol error: it is ignored and no valid strobe is issued.
- Addresses pass through unmodified; the arbiter does no alignment or masking.

## Timing
- Reset (i_rst_n low, async): state=IDLE, owner=0, last=0.
- While reset is asserted:
  - o_mem_ren = o_mem_wen = 0, o_mem_addr = o_mem_wdata = 0.
  - o_I/D_ready = 0 and o_I/D_valid = 0, regardless of inputs.
- Reset during RD_WAIT abandons the read. A later i_mem_valid for that read is dropped.
- Accept path: 0 added cycles. A request and its ready occur in the same cycle as the memory accept.
- Read response: o_X_valid coincides with i_mem_valid in the same cycle, combinationally.
- After a read response, the earliest next grant is the following cycle.
- Write-after-write with i_mem_ready held high: one write per cycle, alternating grant if round-robin is enabled.
- i_mem_ready low: the grant is still computed but ready=0. Memory strobes stay asserted, per the memory protocol, until accepted.
- `last` updates only on accept, not on a bare grant.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On a simultaneous request, the port ≠ `last` wins.
  - `last` is loaded with the winner on every accept.
- Not defined:
  - Fixed priority, D over I.
  - `last` is not implemented; it has no storage.

## Test plan
- I read alone:
  - Stimulus: i_I_ren=1, addr 0x0000_0100, i_mem_ready=1; i_mem_valid=1 with rdata 0xDEAD_BEEF three cycles later.
  - Required: o_mem_ren=1 and addr 0x100 in cycle 0; o_I_ready=1 in cycle 0; o_I_valid=1 with 0xDEAD_BEEF in cycle 3; o_D_valid=0 throughout.
- Simultaneous requests, fixed priority:
  - Stimulus: I reads 0x200 and D writes 0x300/0x1234_5678 in the same cycle.
  - Required: the D write is accepted first; the I read is accepted the next cycle.
  - With `MEM_ARB_ROUND_ROBIN_EN` and last=D: the I read goes first.
- Blocking during RD_WAIT:
  - Stimulus: D read accepted; I write presented while the read is outstanding.
  - Required: o_I_ready=0 until the cycle after D's i_mem_valid; the I write is accepted then.
- Backpressure:
  - Stimulus: D write 0x40 with i_mem_ready=0 for 4 cycles, then 1.
  - Required: o_mem_wen=1 and addr 0x40 stable all 5 cycles; o_D_ready=1 only in cycle 5.
- Async reset mid-read:
  - Stimulus: I read accepted; i_rst_n pulsed low between clock edges; stale i_mem_valid arrives afterwards.
  - Required: all outputs 0 immediately on reset; the stale valid produces no o_I_valid or o_D_valid.
- Both strobes high on one port:
  - Stimulus: i_D_ren=1 and i_D_wen=1, addr 0x80.
  - Required: o_mem_ren=1, o_mem_wen=0, state enters RD_WAIT.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter between the I-cache and D-cache memory-side
// interfaces and a single word-granular external memory port. One transaction
// is granted at a time; the single outstanding read is tracked and its valid
// strobe is routed back to the port that issued it.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration
// on simultaneous requests. Without it, D has fixed priority over I.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_X_ren/wen/addr/wdata  port X request (X = I, D), held until o_X_ready
//   o_X_ready               port X request accepted this cycle
//   o_X_valid/rdata         port X read response (rdata is broadcast)
//   o_mem_*                 request to memory, zero when nothing is granted
//   i_mem_ready             memory accepts the presented request this cycle
//   i_mem_valid/rdata       memory read response, one cycle per read
module mem_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_I_ren,
  input  logic        i_I_wen,
  input  logic [31:0] i_I_addr,
  input  logic [31:0] i_I_wdata,
  output logic        o_I_ready,
  output logic        o_I_valid,
  output logic [31:0] o_I_rdata,
  input  logic        i_D_ren,
  input  logic        i_D_wen,
  input  logic [31:0] i_D_addr,
  input  logic [31:0] i_D_wdata,
  output logic        o_D_ready,
  output logic        o_D_valid,
  output logic [31:0] o_D_rdata,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid
);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;   // 0 = I, 1 = D

  logic   req_i, req_d;
  logic   pick_d;             // D wins a simultaneous request
  logic   grant_i, grant_d, grant_any;
  logic   win_ren, win_wen;
  logic   accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic   last_q, last_d;     // last accepted port, 0 = I, 1 = D
`endif

  always_comb begin
    req_i = i_I_ren | i_I_wen;
    req_d = i_D_ren | i_D_wen;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick_d = ~last_q;
`else
    pick_d = 1'b1;
`endif

    // Grants are also gated by reset so every output is quiet while reset is
    // held, whatever the requesters are driving.
    grant_d   = i_rst_n & (state_q == IDLE) & req_d & (~req_i | pick_d);
    grant_i   = i_rst_n & (state_q == IDLE) & req_i & ~grant_d;
    grant_any = grant_i | grant_d;

    win_ren = grant_d ? i_D_ren : (grant_i & i_I_ren);
    win_wen = grant_d ? i_D_wen : (grant_i & i_I_wen);

    o_mem_ren   = win_ren;
    // A request with both strobes high is a read.
    o_mem_wen   = win_wen & ~win_ren;
    o_mem_addr  = grant_d ? i_D_addr  : (grant_i ? i_I_addr  : 32'd0);
    o_mem_wdata = grant_d ? i_D_wdata : (grant_i ? i_I_wdata : 32'd0);

    accept    = grant_any & i_mem_ready;
    o_I_ready = grant_i & i_mem_ready;
    o_D_ready = grant_d & i_mem_ready;

    // Valid in IDLE (including a stale response after reset) is dropped.
    o_I_valid = i_rst_n & i_mem_valid & (state_q == RD_WAIT) & ~owner_q;
    o_D_valid = i_rst_n & i_mem_valid & (state_q == RD_WAIT) &  owner_q;
    o_I_rdata = i_rst_n ? i_mem_rdata : 32'd0;
    o_D_rdata = i_rst_n ? i_mem_rdata : 32'd0;

    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (accept && win_ren) begin
          state_d = RD_WAIT;
          owner_d = grant_d;
        end
      end
      RD_WAIT: begin
        if (i_mem_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d = accept ? grant_d : last_q;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Directed cache/memory stimulus; read
// responses are checked through a scoreboard that is loaded when a read is
// issued and drained when the arbiter raises a valid strobe.
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_I_ren, i_I_wen, i_D_ren, i_D_wen;
  logic [31:0] i_I_addr, i_I_wdata, i_D_addr, i_D_wdata;
  logic        o_I_ready, o_I_valid, o_D_ready, o_D_valid;
  logic [31:0] o_I_rdata, o_D_rdata;
  logic        i_mem_ready, i_mem_valid;
  logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic        o_mem_ren, o_mem_wen;

  mem_arbiter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_I_ren(i_I_ren), .i_I_wen(i_I_wen), .i_I_addr(i_I_addr), .i_I_wdata(i_I_wdata),
    .o_I_ready(o_I_ready), .o_I_valid(o_I_valid), .o_I_rdata(o_I_rdata),
    .i_D_ren(i_D_ren), .i_D_wen(i_D_wen), .i_D_addr(i_D_addr), .i_D_wdata(i_D_wdata),
    .o_D_ready(o_D_ready), .o_D_valid(o_D_valid), .o_D_rdata(o_D_rdata),
    .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
    .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        port;   // 0 = I, 1 = D
    logic [31:0] data;
  } rsp_t;

  rsp_t rsp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Response monitor: every valid strobe must match the oldest expected read.
  always @(negedge i_clk) begin
    if (o_I_valid || o_D_valid) begin
      rsp_t e;
      chk("sb_one_hot", {31'd0, o_I_valid & o_D_valid}, 32'd0);
      if (rsp_q.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = rsp_q.pop_front();
        chk("sb_port", {31'd0, o_D_valid}, {31'd0, e.port});
        chk("sb_data", o_D_valid ? o_D_rdata : o_I_rdata, e.data);
      end
    end
  end

  task automatic nxt();           // advance to just after the next rising edge
    @(posedge i_clk); #1;
  endtask

  task automatic smp();           // move to the sampling point of this cycle
    @(negedge i_clk);
  endtask

  task automatic idle_in();
    i_I_ren = 0; i_I_wen = 0; i_I_addr = 0; i_I_wdata = 0;
    i_D_ren = 0; i_D_wen = 0; i_D_addr = 0; i_D_wdata = 0;
    i_mem_ready = 1; i_mem_valid = 0; i_mem_rdata = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mren"},  {31'd0, o_mem_ren}, 32'd0);
    chk({tag, "_mwen"},  {31'd0, o_mem_wen}, 32'd0);
    chk({tag, "_maddr"}, o_mem_addr,  32'd0);
    chk({tag, "_mwdat"}, o_mem_wdata, 32'd0);
    chk({tag, "_rdy"},   {30'd0, o_I_ready, o_D_ready}, 32'd0);
    chk({tag, "_vld"},   {30'd0, o_I_valid, o_D_valid}, 32'd0);
  endtask

  initial begin
    idle_in();
    // Reset held with busy inputs: everything must be quiet.
    i_rst_n = 0;
    i_I_ren = 1; i_I_addr = 32'h11; i_D_wen = 1; i_D_addr = 32'h22; i_D_wdata = 32'h33;
    i_mem_valid = 1; i_mem_rdata = 32'hFFFF_0000;
    #12;
    chk_quiet("rst");
    chk("rst_rdata", o_I_rdata, 32'd0);
    idle_in();
    #2 i_rst_n = 1;
    nxt();

    // ---- I read alone ----
    i_I_ren = 1; i_I_addr = 32'h0000_0100;
    rsp_q.push_back('{port: 1'b0, data: 32'hDEAD_BEEF});
    smp();
    chk("i_rd_mren",  {31'd0, o_mem_ren}, 32'd1);
    chk("i_rd_addr",  o_mem_addr, 32'h100);
    chk("i_rd_ready", {31'd0, o_I_ready}, 32'd1);
    chk("i_rd_dvld",  {31'd0, o_D_valid}, 32'd0);
    nxt(); i_I_ren = 0; i_I_addr = 0;
    smp(); chk("i_rd_wait_mren", {31'd0, o_mem_ren}, 32'd0);
    nxt(); smp();
    chk("i_rd_wait_ivld", {31'd0, o_I_valid}, 32'd0);
    nxt(); i_mem_valid = 1; i_mem_rdata = 32'hDEAD_BEEF;
    smp();
    chk("i_rd_ivld", {31'd0, o_I_valid}, 32'd1);
    chk("i_rd_dvld3", {31'd0, o_D_valid}, 32'd0);
    nxt(); i_mem_valid = 0; i_mem_rdata = 0;

    // ---- Simultaneous: I read 0x200, D write 0x300 ----
    // last is I here, so round-robin also picks D.
    i_I_ren = 1; i_I_addr = 32'h200;
    i_D_wen = 1; i_D_addr = 32'h300; i_D_wdata = 32'h1234_5678;
    rsp_q.push_back('{port: 1'b0, data: 32'h0BAD_F00D});
    smp();
    chk("sim_d_wen",   {31'd0, o_mem_wen}, 32'd1);
    chk("sim_d_ren",   {31'd0, o_mem_ren}, 32'd0);
    chk("sim_d_addr",  o_mem_addr,  32'h300);
    chk("sim_d_wdata", o_mem_wdata, 32'h1234_5678);
    chk("sim_rdy",     {30'd0, o_I_ready, o_D_ready}, 32'b01);
    nxt(); i_D_wen = 0; i_D_addr = 0; i_D_wdata = 0;
    smp();
    chk("sim_i_ren",  {31'd0, o_mem_ren}, 32'd1);
    chk("sim_i_addr", o_mem_addr, 32'h200);
    chk("sim_i_rdy",  {30'd0, o_I_ready, o_D_ready}, 32'b10);
    nxt(); i_I_ren = 0; i_I_addr = 0;
    i_mem_valid = 1; i_mem_rdata = 32'h0BAD_F00D;
    nxt(); i_mem_valid = 0; i_mem_rdata = 0;

    // D write alone leaves last = D; then a second simultaneous pair.
    i_D_wen = 1; i_D_addr = 32'h304; i_D_wdata = 32'hA;
    smp(); chk("pre_d_rdy", {31'd0, o_D_ready}, 32'd1);
    nxt();
    i_I_ren = 1; i_I_addr = 32'h208;
    i_D_wen = 1; i_D_addr = 32'h308; i_D_wdata = 32'hB;
    smp();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("sim2_addr", o_mem_addr, 32'h208);
    chk("sim2_rdy",  {30'd0, o_I_ready, o_D_ready}, 32'b10);
    nxt(); i_I_ren = 0; i_I_addr = 0;
    rsp_q.push_back('{port: 1'b0, data: 32'h2080_2080});
    i_mem_valid = 1; i_mem_rdata = 32'h2080_2080;
    smp(); chk("sim2_hold_d", {31'd0, o_D_ready}, 32'd0);
    nxt(); i_mem_valid = 0; i_mem_rdata = 0;
    smp(); chk("sim2_d_addr", o_mem_addr, 32'h308);
    chk("sim2_d_rdy", {31'd0, o_D_ready}, 32'd1);
    nxt(); i_D_wen = 0; i_D_addr = 0; i_D_wdata = 0;
`else
    chk("sim2_addr", o_mem_addr, 32'h308);
    chk("sim2_rdy",  {30'd0, o_I_ready, o_D_ready}, 32'b01);
    nxt(); i_D_wen = 0; i_D_addr = 0; i_D_wdata = 0;
    smp(); chk("sim2_i_addr", o_mem_addr, 32'h208);
    chk("sim2_i_rdy", {31'd0, o_I_ready}, 32'd1);
    nxt(); i_I_ren = 0; i_I_addr = 0;
    rsp_q.push_back('{port: 1'b0, data: 32'h2080_2080});
    i_mem_valid = 1; i_mem_rdata = 32'h2080_2080;
    nxt(); i_mem_valid = 0; i_mem_rdata = 0;
`endif

    // ---- Blocking during RD_WAIT ----
    i_D_ren = 1; i_D_addr = 32'h500;
    rsp_q.push_back('{port: 1'b1, data: 32'hCAFE_0001});
    smp(); chk("blk_d_rdy", {31'd0, o_D_ready}, 32'd1);
    nxt(); i_D_ren = 0; i_D_addr = 0;
    i_I_wen = 1; i_I_addr = 32'h600; i_I_wdata = 32'h55;
    for (int c = 0; c < 2; c++) begin
      smp();
      chk("blk_i_rdy", {31'd0, o_I_ready}, 32'd0);
      chk("blk_mwen",  {31'd0, o_mem_wen}, 32'd0);
      nxt();
    end
    i_mem_valid = 1; i_mem_rdata = 32'hCAFE_0001;
    smp(); chk("blk_i_rdy_v", {31'd0, o_I_ready}, 32'd0);
    nxt(); i_mem_valid = 0; i_mem_rdata = 0;
    smp();
    chk("blk_i_rdy_after", {31'd0, o_I_ready}, 32'd1);
    chk("blk_i_addr", o_mem_addr, 32'h600);
    chk("blk_i_wdat", o_mem_wdata, 32'h55);
    nxt(); i_I_wen = 0; i_I_addr = 0; i_I_wdata = 0;

    // ---- Backpressure ----
    i_mem_ready = 0;
    i_D_wen = 1; i_D_addr = 32'h40; i_D_wdata = 32'h77;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) i_mem_ready = 1;
      smp();
      chk("bp_mwen", {31'd0, o_mem_wen}, 32'd1);
      chk("bp_addr", o_mem_addr, 32'h40);
      chk("bp_d_rdy", {31'd0, o_D_ready}, (c == 4) ? 32'd1 : 32'd0);
      nxt();
    end
    i_D_wen = 0; i_D_addr = 0; i_D_wdata = 0;

    // ---- Async reset mid-read; stale valid afterwards ----
    i_I_ren = 1; i_I_addr = 32'h700;
    smp(); chk("rr_i_rdy", {31'd0, o_I_ready}, 32'd1);
    nxt(); i_I_addr = 32'h704;     // keeps requesting across the reset pulse
    smp(); #1 i_rst_n = 0;
    i_mem_valid = 1; i_mem_rdata = 32'h5151_5151;
    #1;
    chk_quiet("arst");
    #1 i_rst_n = 1; i_I_ren = 0; i_I_addr = 0;
    nxt();
    smp();                            // stale valid still high: IDLE now
    chk("stale_vld", {30'd0, o_I_valid, o_D_valid}, 32'd0);
    nxt(); i_mem_valid = 0; i_mem_rdata = 0;
    smp(); chk_quiet("post_rst");
    nxt();

    // ---- Both strobes high on D ----
    i_D_ren = 1; i_D_wen = 1; i_D_addr = 32'h80; i_D_wdata = 32'h99;
    rsp_q.push_back('{port: 1'b1, data: 32'h0808_0808});
    smp();
    chk("both_mren", {31'd0, o_mem_ren}, 32'd1);
    chk("both_mwen", {31'd0, o_mem_wen}, 32'd0);
    chk("both_addr", o_mem_addr, 32'h80);
    nxt(); i_D_ren = 0; i_D_wen = 0; i_D_addr = 0; i_D_wdata = 0;
    i_I_ren = 1; i_I_addr = 32'h900;  // must be blocked: read outstanding
    smp(); chk("both_rdwait", {31'd0, o_I_ready}, 32'd0);
    nxt(); i_I_ren = 0; i_I_addr = 0;
    i_mem_valid = 1; i_mem_rdata = 32'h0808_0808;
    nxt(); i_mem_valid = 0; i_mem_rdata = 0;

    nxt(); nxt();
    chk("sb_drained", rsp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
